// File: rtl/cd_timer_array_pkg.sv
// Shared register-map constants and parameter helpers for the countdown timer bank.
package timer_pkg;

  localparam logic REG_COUNT = 1'b0;
  localparam logic REG_CTRL  = 1'b1;

  localparam int CTRL_AUTO  = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_PAUSE = 2;
  localparam int CTRL_EXP   = 8;

  localparam int DATA_W = 16;

  function automatic int tick_div(input int clock_hz, input int tick_hz);
    return clock_hz / tick_hz;
  endfunction

  // Prescaler needs to hold 0..div-1; keep at least one bit so TICK_DIV=1 still elaborates.
  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/cd_timer_array_channel.sv
// One countdown channel: counter, reload value, tick prescaler, control bits and sticky expiry.
module timer_channel
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_count,
  input  logic                wr_ctrl,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   count,
  output logic [DATA_W-1:0]   ctrl_rd,
  output logic                irq
);

  localparam int                PRE_W    = pre_width(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] reload_q, reload_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic                 auto_q, auto_d;
  logic                 ie_q, ie_d;
  logic                 pause_q, pause_d;
  logic                 exp_q, exp_d;

  logic active;
  logic tick;
  logic unused_wr;

  assign unused_wr = ^wr_data;

  assign active = (cnt_q != '0) && !pause_q;
  assign tick   = active && (pre_q == PRE_LAST);

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    pause_d  = pause_q;
    exp_d    = exp_q;

    if (active) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // W1C is applied first so an expiry on the same edge overrides it.
    if (wr_ctrl) begin
      auto_d  = wr_data[CTRL_AUTO];
      ie_d    = wr_data[CTRL_IE];
      pause_d = wr_data[CTRL_PAUSE];
      if (wr_data[CTRL_EXP]) exp_d = 1'b0;
    end

    if (tick) begin
      if (cnt_q > CNT_WIDTH'(1)) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end else begin
        exp_d = 1'b1;
        cnt_d = (auto_q && (reload_q != '0)) ? reload_q : '0;
      end
    end

    // A COUNT write restarts the channel outright, beating any tick this cycle.
    if (wr_count) begin
      cnt_d    = wr_data[CNT_WIDTH-1:0];
      reload_d = wr_data[CNT_WIDTH-1:0];
      pre_d    = '0;
      exp_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      pause_q  <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      pause_q  <= pause_d;
      exp_q    <= exp_d;
    end
  end

  assign count = DATA_W'(cnt_q);
  assign irq   = exp_q & ie_q;

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[CTRL_AUTO]  = auto_q;
    ctrl_rd[CTRL_IE]    = ie_q;
    ctrl_rd[CTRL_PAUSE] = pause_q;
    ctrl_rd[CTRL_EXP]   = exp_q;
  end

endmodule

// File: rtl/cd_timer_array.sv
// Memory-mapped bank of independent countdown timers: address decode, read mux, channel array.
module cd_timer_array
  import timer_pkg::*;
#(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int TICK_HZ    = 1_000,
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic [NUM_CH-1:0]     irq
);

  localparam int TICK_DIV = tick_div(CLOCK_HZ, TICK_HZ);
  localparam int CH_W     = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;

  if (TICK_DIV < 1) begin : g_bad_div
    $error("cd_timer_array: CLOCK_HZ/TICK_HZ must be >= 1");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("cd_timer_array: NUM_CH must be 1..16");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 16) begin : g_bad_cnt
    $error("cd_timer_array: CNT_WIDTH must be 1..16");
  end
  if (ADDR_WIDTH < $clog2(NUM_CH) + 2) begin : g_bad_addr
    $error("cd_timer_array: ADDR_WIDTH too small for NUM_CH");
  end

  logic [CH_W-1:0]               chan;
  logic                          reg_sel;
  logic                          unused_addr;
  logic [NUM_CH-1:0]             wr_count;
  logic [NUM_CH-1:0]             wr_ctrl;
  logic [NUM_CH-1:0][DATA_W-1:0] count;
  logic [NUM_CH-1:0][DATA_W-1:0] ctrl_rd;

  if (ADDR_WIDTH > 2) begin : g_chan
    assign chan = addr[ADDR_WIDTH-1:2];
  end else begin : g_chan_one
    assign chan = '0;
  end

  assign reg_sel     = addr[1];
  assign unused_addr = addr[0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_count[c] = wr && (chan == CH_W'(c)) && (reg_sel == REG_COUNT);
    assign wr_ctrl[c]  = wr && (chan == CH_W'(c)) && (reg_sel == REG_CTRL);

    timer_channel #(
      .TICK_DIV  (TICK_DIV),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_count (wr_count[c]),
      .wr_ctrl  (wr_ctrl[c]),
      .wr_data  (wr_data),
      .count    (count[c]),
      .ctrl_rd  (ctrl_rd[c]),
      .irq      (irq[c])
    );
  end

  // Channel indices past NUM_CH match nothing and fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan == CH_W'(c)) rd_data = reg_sel ? ctrl_rd[c] : count[c];
    end
  end

endmodule
